// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: KSA state encoding, S-box depth, default key length
// and the key-byte extraction helper used by the key selector.
package rc4_pkg;

  localparam int RAM_DEPTH     = 256;
  localparam int KEY_BYTES_DEF = 3;
  // Widest key the byte extractor accepts; longer keys would be truncated.
  localparam int MAX_KEY_BYTES = 32;
  localparam int MAX_KEY_BITS  = MAX_KEY_BYTES * 8;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_I,
    S_WT_I,
    S_CAP_I,
    S_RD_J,
    S_WT_J,
    S_CAP_J,
    S_WR_I,
    S_WR_J,
    S_DONE
  } ksa_state_t;

  // Byte idx of an nbytes-long key, byte 0 being the most significant byte.
  // The key is passed right-justified in a MAX_KEY_BITS-wide vector.
  function automatic logic [7:0] key_byte(input logic [MAX_KEY_BITS-1:0] key,
                                          input logic [31:0]             nbytes,
                                          input logic [31:0]             idx);
    logic [MAX_KEY_BITS-1:0] shifted;
    shifted = key >> (32'd8 * (nbytes - 32'd1 - idx));
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/ksa_swapper_if.sv
// Sequencer-facing bundle of the KSA stage: start/finished handshake plus the
// single-port S RAM bus (ram_out arrives two cycles after the address).
interface ksa_swapper_if #(
  parameter int RAM_WIDTH = 8
);
  logic                 start;
  logic                 finished;
  logic [RAM_WIDTH-1:0] address;
  logic [RAM_WIDTH-1:0] ram_in;
  logic                 write_enable;
  logic [RAM_WIDTH-1:0] ram_out;

  // master: the KSA stage; slave: sequencer/RAM side
  modport master (
    input  start, ram_out,
    output finished, address, ram_in, write_enable
  );
  modport slave (
    output start, ram_out,
    input  finished, address, ram_in, write_enable
  );
endinterface

// File: rtl/ksa_key_selector.sv
// Key byte selector: key_idx counts 0..KEY_BYTES-1 and wraps, and the current
// key byte is muxed out of the secret key (byte 0 = most significant byte).
module ksa_key_selector
  import rc4_pkg::*;
#(
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   clear,
  input  logic                   advance,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  output logic [7:0]             key_byte_out
);

  localparam int KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KIDX_W-1:0] LAST_IDX = KIDX_W'(KEY_BYTES - 1);

  logic [KIDX_W-1:0] key_idx;

  // Key index: cleared at end of run, advanced once per completed iteration.
  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_idx <= '0;
    end else if (clear) begin
      key_idx <= '0;
    end else if (advance) begin
      key_idx <= (key_idx == LAST_IDX) ? '0 : key_idx + 1'b1;
    end
  end

  assign key_byte_out = key_byte(MAX_KEY_BITS'(secret_key), 32'(KEY_BYTES), 32'(key_idx));

endmodule

// File: rtl/ksa_swapper.sv
// RC4 key-scheduling stage. Runs after the S RAM holds S[i]=i; for i=0..255
// computes j += S[i] + key[i mod KEY_BYTES] and swaps S[i], S[j] through the
// shared single-port RAM (8 cycles per iteration).
// Optional build macro KSA_SAME_INDEX_SKIP_EN: when the new j equals i the
// read/write of S[j] is skipped, giving a 3-cycle iteration with no writes.
module ksa_swapper
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH = 8,
  parameter int KEY_BYTES = KEY_BYTES_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  ksa_swapper_if.master          bus
);

  ksa_state_t           state_q, state_d;
  logic [RAM_WIDTH-1:0] i_q, j_q, si_q, sj_q;
  logic [RAM_WIDTH-1:0] j_new;
  logic [7:0]           key_b;
  logic                 start_q;
  logic                 start_acc;
  logic                 last_i;
  logic                 same_idx_skip;
  logic                 iter_adv;

  assign start_acc = bus.start & ~start_q;
  assign last_i    = (i_q == {RAM_WIDTH{1'b1}});
  assign j_new     = j_q + bus.ram_out + RAM_WIDTH'(key_b);

`ifdef KSA_SAME_INDEX_SKIP_EN
  assign same_idx_skip = (state_q == S_CAP_I) && (j_new == i_q);
`else
  assign same_idx_skip = 1'b0;
`endif

  // i (and the key index) step after the last write, or after a skipped swap;
  // the final iteration leaves them for DONE to clear.
  assign iter_adv = ((state_q == S_WR_J) || same_idx_skip) && !last_i;

  ksa_key_selector #(
    .KEY_BYTES (KEY_BYTES)
  ) u_key_sel (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear        (state_q == S_DONE),
    .advance      (iter_adv),
    .secret_key   (secret_key),
    .key_byte_out (key_b)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed one-cycle walk through the read/capture/write steps.
  // NOTE: every combinational output gets a default first so no path through
  // the case leaves a value unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_RD_I;
      S_RD_I:  state_d = S_WT_I;
      S_WT_I:  state_d = S_CAP_I;
      S_CAP_I: begin
        if (same_idx_skip) state_d = last_i ? S_DONE : S_RD_I;
        else               state_d = S_RD_J;
      end
      S_RD_J:  state_d = S_WT_J;
      S_WT_J:  state_d = S_CAP_J;
      S_CAP_J: state_d = S_WR_I;
      S_WR_I:  state_d = S_WR_J;
      S_WR_J:  state_d = last_i ? S_DONE : S_RD_I;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: start edge register, captured S values, i and j indices.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= 1'b0;
      i_q     <= '0;
      j_q     <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      start_q <= bus.start;
      if (state_q == S_CAP_I) begin
        si_q <= bus.ram_out;
        j_q  <= j_new;
      end
      if (state_q == S_CAP_J) sj_q <= bus.ram_out;
      if (iter_adv) i_q <= i_q + 1'b1;
      if (state_q == S_DONE) begin
        i_q <= '0;
        j_q <= '0;
      end
    end
  end

  // Output decode: RAM address/data/strobe and the finished pulse per state.
  always_comb begin
    bus.address      = '0;
    bus.ram_in       = '0;
    bus.write_enable = 1'b0;
    bus.finished     = 1'b0;
    case (state_q)
      S_RD_I, S_WT_I: bus.address = i_q;
      S_RD_J, S_WT_J: bus.address = j_q;
      S_WR_I: begin
        bus.address      = i_q;
        bus.ram_in       = sj_q;
        bus.write_enable = 1'b1;
      end
      S_WR_J: begin
        bus.address      = j_q;
        bus.ram_in       = si_q;
        bus.write_enable = 1'b1;
      end
      S_DONE:  bus.finished = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_swapper.sv
// Testbench for ksa_swapper: two-cycle-latency S RAM model, a plain RC4 KSA
// reference computed in software, and one task per scenario.
module tb_ksa_swapper;

`ifdef KSA_SAME_INDEX_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b1;
  logic [23:0] secret_key = '0;

  ksa_swapper_if #(.RAM_WIDTH(8)) bus ();

  ksa_swapper #(
    .RAM_WIDTH (8),
    .KEY_BYTES (3)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .secret_key (secret_key),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // S RAM model: address registered, data out one cycle later; write log.
  logic [7:0] mem [256];
  logic [7:0] rd_addr_q;
  logic       ram_init = 1'b0;
  logic [7:0] log_addr [8192];
  logic [7:0] log_data [8192];
  int         wr_total = 0;

  always @(posedge clk) begin
    rd_addr_q   <= bus.address;
    bus.ram_out <= mem[rd_addr_q];
    if (ram_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (bus.write_enable) begin
      mem[bus.address]          <= bus.ram_in;
      log_addr[wr_total % 8192] <= bus.address;
      log_data[wr_total % 8192] <= bus.ram_in;
      wr_total                  <= wr_total + 1;
    end
  end

  // Reference model results
  logic [7:0] exp_s [256];
  int         exp_cycles;
  int         iter_start [257];
  logic [7:0] exp_wa [512];
  logic [7:0] exp_wd [512];
  int         exp_wi [512];
  int         exp_wr_n;

  int         total = 0;
  int         bad   = 0;
  int         run_base;
  logic [7:0] addr_at [5001];
  logic       we_at   [5001];

  // Plain RC4 key schedule with per-iteration cycle accounting.
  task automatic model_ksa(input logic [23:0] key);
    logic [7:0] s [256];
    logic [7:0] j, kb, t;
    int cyc;
    j = 8'd0;
    cyc = 1;
    exp_wr_n = 0;
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    for (int i = 0; i < 256; i++) begin
      iter_start[i] = cyc;
      kb = 8'(key >> (8 * (2 - (i % 3))));
      j = j + s[i] + kb;
      if (SKIP && (int'(j) == i)) begin
        cyc += 3;
      end else begin
        exp_wa[exp_wr_n] = 8'(i); exp_wd[exp_wr_n] = s[j]; exp_wi[exp_wr_n] = i; exp_wr_n++;
        exp_wa[exp_wr_n] = j;     exp_wd[exp_wr_n] = s[i]; exp_wi[exp_wr_n] = i; exp_wr_n++;
        t = s[i]; s[i] = s[j]; s[j] = t;
        cyc += 8;
      end
    end
    iter_start[256] = cyc;
    exp_cycles = cyc;
    exp_s = s;
  endtask

  task automatic preload_ram();
    @(negedge clk);
    ram_init = 1'b1;
    @(negedge clk);
    ram_init = 1'b0;
  endtask

  // One complete run. mode 0: single start pulse; 1: start held 5000 cycles;
  // 2: pulse plus a second pulse mid-run, watched for 5000 cycles.
  task automatic run_full(input logic [23:0] key, input int mode, input string name);
    int fin_cycle, pulses, limit, n_bad, first_bad, got_n;
    model_ksa(key);
    preload_ram();
    secret_key = key;
    run_base   = wr_total;
    bus.start  = 1'b1;
    fin_cycle  = 0;
    pulses     = 0;
    limit      = (mode == 0) ? 2600 : 5000;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (mode != 1 && n == 1) bus.start = 1'b0;
      if (mode == 2 && n == 500) bus.start = 1'b1;
      if (mode == 2 && n == 501) bus.start = 1'b0;
      addr_at[n] = bus.address;
      we_at[n]   = bus.write_enable;
      if (bus.finished === 1'b1) begin
        pulses++;
        if (fin_cycle == 0) fin_cycle = n;
      end
      if (mode == 0 && fin_cycle != 0 && n == fin_cycle + 1) begin
        total++;
        if (bus.finished !== 1'b0) begin
          bad++;
          $display("FAIL %s finished_width: got %b at cycle %0d, want 0", name, bus.finished, n);
        end
        break;
      end
    end
    bus.start = 1'b0;

    total++;
    if (fin_cycle != exp_cycles) begin
      bad++;
      $display("FAIL %s latency: finished cycle got %0d, want %0d (0 = never)", name, fin_cycle, exp_cycles);
    end
    if (mode != 0) begin
      total++;
      if (pulses != 1) begin
        bad++;
        $display("FAIL %s pulse_count: got %0d, want 1", name, pulses);
      end
    end

    n_bad = 0;
    first_bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_s[k]) begin
        if (n_bad == 0) first_bad = k;
        n_bad++;
      end
    end
    total++;
    if (n_bad != 0) begin
      bad++;
      $display("FAIL %s final_ram: %0d entries differ, S[%0d] got %h want %h",
               name, n_bad, first_bad, mem[first_bad], exp_s[first_bad]);
    end

    got_n = wr_total - run_base;
    total++;
    if (got_n != exp_wr_n) begin
      bad++;
      $display("FAIL %s write_count: got %0d, want %0d", name, got_n, exp_wr_n);
    end else begin
      n_bad = 0;
      first_bad = 0;
      for (int w = 0; w < exp_wr_n; w++) begin
        if (log_addr[(run_base + w) % 8192] !== exp_wa[w] ||
            log_data[(run_base + w) % 8192] !== exp_wd[w]) begin
          if (n_bad == 0) first_bad = w;
          n_bad++;
        end
      end
      total++;
      if (n_bad != 0) begin
        bad++;
        $display("FAIL %s write_seq: %0d differ, write %0d got %h<=%h want %h<=%h", name, n_bad,
                 first_bad, log_addr[(run_base + first_bad) % 8192],
                 log_data[(run_base + first_bad) % 8192], exp_wa[first_bad], exp_wd[first_bad]);
      end
    end
  endtask

  // Checks the two writes of iteration it against fixed (address, data) pairs.
  task automatic check_iter_writes(input int it, input logic [7:0] a0, input logic [7:0] d0,
                                   input logic [7:0] a1, input logic [7:0] d1, input string name);
    int w;
    w = -1;
    for (int k = 0; k < exp_wr_n; k++) if (exp_wi[k] == it && w < 0) w = k;
    total++;
    if (w < 0 || (wr_total - run_base) < w + 2) begin
      bad++;
      $display("FAIL %s iter_%0d_writes: got none, want %h<=%h then %h<=%h", name, it, a0, d0, a1, d1);
    end else begin
      if (log_addr[(run_base + w) % 8192] !== a0 || log_data[(run_base + w) % 8192] !== d0) begin
        bad++;
        $display("FAIL %s wr_i: got %h<=%h, want %h<=%h", name,
                 log_addr[(run_base + w) % 8192], log_data[(run_base + w) % 8192], a0, d0);
      end
      total++;
      if (log_addr[(run_base + w + 1) % 8192] !== a1 || log_data[(run_base + w + 1) % 8192] !== d1) begin
        bad++;
        $display("FAIL %s wr_j: got %h<=%h, want %h<=%h", name,
                 log_addr[(run_base + w + 1) % 8192], log_data[(run_base + w + 1) % 8192], a1, d1);
      end
    end
  endtask

  task automatic test_reset();
    int base;
    bit seen_fin, seen_addr;
    bus.start = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.finished !== 1'b0)     begin bad++; $display("FAIL reset finished: got %b want 0", bus.finished); end
    total++; if (bus.write_enable !== 1'b0) begin bad++; $display("FAIL reset write_enable: got %b want 0", bus.write_enable); end
    total++; if (bus.address !== 8'h00)     begin bad++; $display("FAIL reset address: got %h want 00", bus.address); end
    total++; if (bus.ram_in !== 8'h00)      begin bad++; $display("FAIL reset ram_in: got %h want 00", bus.ram_in); end
    reset_n = 1'b1;
    base = wr_total;
    seen_fin = 1'b0;
    seen_addr = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.finished !== 1'b0) seen_fin = 1'b1;
      if (bus.address !== 8'h00) seen_addr = 1'b1;
    end
    total++; if (wr_total != base) begin bad++; $display("FAIL idle writes: got %0d want 0", wr_total - base); end
    total++; if (seen_fin)  begin bad++; $display("FAIL idle finished: got pulse want none"); end
    total++; if (seen_addr) begin bad++; $display("FAIL idle address: got nonzero want 00"); end
  endtask

  task automatic test_full_run();
    run_full(24'h000000, 0, "full_key0");
    check_iter_writes(2, 8'd2, 8'd3, 8'd3, 8'd2, "full_key0");
  endtask

  task automatic test_iteration();
    run_full(24'h0003FF, 0, "key_0003ff");
    check_iter_writes(1, 8'd1, 8'd4, 8'd4, 8'd1, "key_0003ff");
  endtask

  task automatic test_random_keys();
    for (int r = 0; r < 2; r++) run_full(24'($urandom), 0, "random_key");
  endtask

  task automatic test_start_held();
    run_full(24'($urandom), 1, "start_held");
    run_full(24'($urandom), 2, "start_repulse");
  endtask

  task automatic test_reset_mid_run();
    logic [23:0] key;
    int target;
    key = 24'($urandom);
    model_ksa(key);
    preload_ram();
    secret_key = key;
    bus.start = 1'b1;
    target = (iter_start[101] - iter_start[100] == 8) ? iter_start[100] + 6 : iter_start[100];
    for (int n = 1; n <= target; n++) begin
      @(negedge clk);
      if (n == 1) bus.start = 1'b0;
      if (n == iter_start[100]) begin
        total++;
        if (bus.address !== 8'd100) begin
          bad++;
          $display("FAIL midrun rd_i_address: got %h want %h", bus.address, 8'd100);
        end
      end
    end
    if (target != iter_start[100]) begin
      total++;
      if (bus.write_enable !== 1'b1 || bus.address !== 8'd100) begin
        bad++;
        $display("FAIL midrun wr_i: got we=%b addr=%h want we=1 addr=64", bus.write_enable, bus.address);
      end
    end
    #1 reset_n = 1'b0;
    #1;
    total++; if (bus.address !== 8'h00)     begin bad++; $display("FAIL async_reset address: got %h want 00", bus.address); end
    total++; if (bus.write_enable !== 1'b0) begin bad++; $display("FAIL async_reset write_enable: got %b want 0", bus.write_enable); end
    total++; if (bus.ram_in !== 8'h00)      begin bad++; $display("FAIL async_reset ram_in: got %h want 00", bus.ram_in); end
    total++; if (bus.finished !== 1'b0)     begin bad++; $display("FAIL async_reset finished: got %b want 0", bus.finished); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    run_full(key, 0, "restart");
  endtask

  task automatic test_same_index();
    int s1, s2, wins, want_w;
    run_full(24'h000000, 0, "same_index");
    s1 = iter_start[1];
    s2 = iter_start[2];
    want_w = SKIP ? 0 : 2;
    wins = 0;
    for (int c = s1; c < s2; c++) if (we_at[c] === 1'b1) wins++;
    total++;
    if (wins != want_w) begin
      bad++;
      $display("FAIL same_index writes_i1: got %0d want %0d", wins, want_w);
    end
    total++;
    if (addr_at[s2] !== 8'd2) begin
      bad++;
      $display("FAIL same_index next_iter_address at cycle %0d: got %h want 02", s2, addr_at[s2]);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_full_run();
    test_iteration();
    test_random_keys();
    test_start_held();
    test_reset_mid_run();
    test_same_index();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
